sisc_ctrl_mc: RTL and testbench

Multi-cycle control FSM for the SISC datapath, the successor to the fixed 7-state controller. It adds memory instructions (LOD/STR/SWP) with a wait-state handshake to instruction and data memory, a parametrised status/mask width, and a short path for branch/NOOP. It has a synthesizable HALT state in place of the simulation stop. It drives the PC, IR, register file, ALU and data memory control inputs.

---
 rtl/sisc_ctrl_mc_pkg.sv | 40 ++++
 rtl/sisc_ctrl_mc_if.sv | 36 +++
 rtl/sisc_ctrl_mc_br_cond.sv | 30 +++
 rtl/sisc_ctrl_mc.sv | 122 ++++++++++++
 tb/tb_sisc_ctrl_mc.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/sisc_ctrl_mc_pkg.sv
// rtl/sisc_ctrl_mc_pkg.sv - shared encodings for the SISC multi-cycle controller
package sisc_ctrl_pkg;

  // FSM state encodings (4-bit debug field)
  localparam logic [3:0] ST_START1  = 4'd0;
  localparam logic [3:0] ST_FETCH   = 4'd1;
  localparam logic [3:0] ST_DECODE  = 4'd2;
  localparam logic [3:0] ST_EXECUTE = 4'd3;
  localparam logic [3:0] ST_MEM     = 4'd4;
  localparam logic [3:0] ST_WB      = 4'd5;
  localparam logic [3:0] ST_WB2     = 4'd6;
  localparam logic [3:0] ST_HALT    = 4'd7;

  // Opcodes
  localparam logic [3:0] OP_NOOP = 4'd0;
  localparam logic [3:0] OP_LOD  = 4'd1;
  localparam logic [3:0] OP_STR  = 4'd2;
  localparam logic [3:0] OP_SWP  = 4'd3;
  localparam logic [3:0] OP_BRA  = 4'd4;
  localparam logic [3:0] OP_BRR  = 4'd5;
  localparam logic [3:0] OP_BNE  = 4'd6;
  localparam logic [3:0] OP_BNR  = 4'd7;
  localparam logic [3:0] OP_ALU  = 4'd8;
  localparam logic [3:0] OP_HLT  = 4'd15;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_RS  = 2'd2;

  // ALU function codes
  localparam logic [1:0] ALU_PASS = 2'b10;
  localparam logic [1:0] ALU_ADDI = 2'b01;

  // Instructions that wait on the data memory handshake
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOD) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/sisc_ctrl_mc_if.sv
// rtl/sisc_ctrl_mc_if.sv - controller to datapath/memory signal bundle
interface sisc_ctrl_mc_if #(
  parameter int MM_W = 4
);
  logic [3:0]      opcode;
  logic [MM_W-1:0] mm;
  logic [MM_W-1:0] stat;
  logic            mem_ack;
  logic            rf_we;
  logic            rf_wsel;
  logic [1:0]      wb_sel;
  logic [1:0]      alu_op;
  logic            br_sel;
  logic            pc_rst;
  logic            pc_write;
  logic            pc_sel;
  logic            ir_load;
  logic            dm_we;
  logic            dm_re;
  logic            halted;
  logic [3:0]      state;

  // Controller side
  modport master (
    input  opcode, mm, stat, mem_ack,
    output rf_we, rf_wsel, wb_sel, alu_op, br_sel, pc_rst, pc_write,
           pc_sel, ir_load, dm_we, dm_re, halted, state
  );

  // Datapath / memory side
  modport slave (
    output opcode, mm, stat, mem_ack,
    input  rf_we, rf_wsel, wb_sel, alu_op, br_sel, pc_rst, pc_write,
           pc_sel, ir_load, dm_we, dm_re, halted, state
  );
endinterface

// File: rtl/sisc_ctrl_mc_br_cond.sv
// rtl/sisc_ctrl_mc_br_cond.sv - branch condition and target-mode decode
module sisc_br_cond
  import sisc_ctrl_pkg::*;
#(
  parameter int MM_W = 4
) (
  input  logic [3:0]      opcode,
  input  logic [MM_W-1:0] mm,
  input  logic [MM_W-1:0] stat,
  output logic            take,
  output logic            br_sel
);

  logic hit;
  assign hit = |(mm & stat);

  // BRA/BRR branch on any masked status bit set, BNE/BNR on none set
  always_comb begin
    take   = 1'b0;
    br_sel = 1'b0;
    case (opcode)
      OP_BRA: begin take = hit;  br_sel = 1'b1; end
      OP_BRR: begin take = hit;  end
      OP_BNE: begin take = !hit; br_sel = 1'b1; end
      OP_BNR: begin take = !hit; end
      default: ;
    endcase
  end

endmodule

// File: rtl/sisc_ctrl_mc.sv
// rtl/sisc_ctrl_mc.sv - multi-cycle SISC control FSM with memory wait states
module sisc_ctrl_mc
  import sisc_ctrl_pkg::*;
#(
  parameter int MM_W        = 4,
  parameter bit USE_MEM_ACK = 1'b1,
  parameter int AM_IMM      = 8
) (
  input logic             clk,
  input logic             rst_f,
  sisc_ctrl_mc_if.master  bus
);

  logic [3:0] cur;
  logic [3:0] nxt;
  logic       ack;
  logic       take;
  logic       br_sel_c;
  logic [1:0] exec_alu;

  // Single-cycle memory builds behave as if every transfer acks at once
  assign ack = USE_MEM_ACK ? bus.mem_ack : 1'b1;

  sisc_br_cond #(.MM_W(MM_W)) u_br_cond (
    .opcode (bus.opcode),
    .mm     (bus.mm),
    .stat   (bus.stat),
    .take   (take),
    .br_sel (br_sel_c)
  );

  // ALU function used in EXECUTE and held through MEM
  always_comb begin
    exec_alu = ALU_PASS;
    if (bus.opcode == OP_ALU)
      exec_alu = {1'b0, bus.mm == MM_W'(AM_IMM)};
    else if (is_mem_op(bus.opcode))
      exec_alu = ALU_ADDI;
  end

  // State register; reset forces START1 from any state, HALT included
  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) cur <= ST_START1;
    else        cur <= nxt;
  end

  assign bus.state = cur;

  // Next-state and control outputs decoded from the present state
  always_comb begin
    nxt          = ST_START1;
    bus.rf_we    = 1'b0;
    bus.rf_wsel  = 1'b0;
    bus.wb_sel   = WB_ALU;
    bus.alu_op   = ALU_PASS;
    bus.br_sel   = 1'b0;
    bus.pc_rst   = 1'b0;
    bus.pc_write = 1'b0;
    bus.pc_sel   = 1'b0;
    bus.ir_load  = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_re    = 1'b0;
    bus.halted   = 1'b0;
    case (cur)
      ST_START1: begin
        bus.pc_rst = 1'b1;
        nxt        = ST_FETCH;
      end
      ST_FETCH: begin
        nxt = ST_FETCH;
        if (ack) begin
          bus.ir_load  = 1'b1;
          bus.pc_write = 1'b1;
          nxt          = ST_DECODE;
        end
      end
      ST_DECODE: begin
        bus.pc_sel   = 1'b1;
        bus.br_sel   = br_sel_c;
        bus.pc_write = take;
        case (bus.opcode)
          OP_LOD, OP_STR, OP_SWP, OP_ALU: nxt = ST_EXECUTE;
          OP_HLT:                         nxt = ST_HALT;
          default:                        nxt = ST_FETCH;
        endcase
      end
      ST_EXECUTE: begin
        bus.alu_op = exec_alu;
        nxt        = ST_MEM;
      end
      ST_MEM: begin
        bus.alu_op = exec_alu;
        bus.dm_re  = (bus.opcode == OP_LOD);
        bus.dm_we  = (bus.opcode == OP_STR);
        if (is_mem_op(bus.opcode) && !ack) nxt = ST_MEM;
        else if (bus.opcode == OP_STR)      nxt = ST_FETCH;
        else                                nxt = ST_WB;
      end
      ST_WB: begin
        nxt = ST_FETCH;
        case (bus.opcode)
          OP_ALU: begin bus.rf_we = 1'b1; bus.wb_sel = WB_ALU; end
          OP_LOD: begin bus.rf_we = 1'b1; bus.wb_sel = WB_MEM; end
          OP_SWP: begin bus.rf_we = 1'b1; bus.wb_sel = WB_RS; nxt = ST_WB2; end
          default: ;
        endcase
      end
      ST_WB2: begin
        bus.rf_we   = 1'b1;
        bus.rf_wsel = 1'b1;
        bus.wb_sel  = WB_ALU;
        nxt         = ST_FETCH;
      end
      ST_HALT: begin
        bus.halted = 1'b1;
        nxt        = ST_HALT;
      end
      default: nxt = ST_START1;
    endcase
  end

endmodule

// File: tb/tb_sisc_ctrl_mc.sv
// tb/tb_sisc_ctrl_mc.sv - self-checking bench for sisc_ctrl_mc
module tb_sisc_ctrl_mc;

  localparam logic [3:0] S_START1 = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2,
                         S_EXECUTE = 4'd3, S_MEM = 4'd4, S_WB = 4'd5,
                         S_WB2 = 4'd6, S_HALT = 4'd7;
  localparam logic [1:0] P = 2'b10, A = 2'b01, Z = 2'b00;

  // Packed output layout: state, alu_op, wb_sel, rf_we, rf_wsel, br_sel,
  // pc_rst, pc_write, pc_sel, ir_load, dm_we, dm_re, halted
  localparam logic [17:0] W_MEM   = 18'h00400, W_RS    = 18'h00800;
  localparam logic [17:0] B_RFWE  = 18'h00200, B_WSEL  = 18'h00100;
  localparam logic [17:0] B_BR    = 18'h00080, B_PCRST = 18'h00040;
  localparam logic [17:0] B_PCW   = 18'h00020, B_PCSEL = 18'h00010;
  localparam logic [17:0] B_IRL   = 18'h00008, B_DMWE  = 18'h00004;
  localparam logic [17:0] B_DMRE  = 18'h00002, B_HALT  = 18'h00001;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  mm;
    logic [3:0]  st;
    logic        ack;
    logic [17:0] exp;
  } vec_t;

  typedef struct {
    logic        sel;
    logic [17:0] exp;
    string       name;
  } sb_t;

  logic clk = 1'b0;
  logic rst_f = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;
  vec_t tbl[$];
  sb_t  sb[$];
  sb_t  cur_e;
  logic [17:0] obs1, obs2;
  logic [17:0] fe, dec;

  always #5 clk = ~clk;

  sisc_ctrl_mc_if #(.MM_W(4)) if1();
  sisc_ctrl_mc_if #(.MM_W(4)) if2();

  sisc_ctrl_mc #(.MM_W(4), .USE_MEM_ACK(1'b1), .AM_IMM(8)) dut1 (
    .clk(clk), .rst_f(rst_f), .bus(if1));
  sisc_ctrl_mc #(.MM_W(4), .USE_MEM_ACK(1'b0), .AM_IMM(8)) dut2 (
    .clk(clk), .rst_f(rst_f), .bus(if2));

  always_comb obs1 = {if1.state, if1.alu_op, if1.wb_sel, if1.rf_we, if1.rf_wsel,
                      if1.br_sel, if1.pc_rst, if1.pc_write, if1.pc_sel,
                      if1.ir_load, if1.dm_we, if1.dm_re, if1.halted};
  always_comb obs2 = {if2.state, if2.alu_op, if2.wb_sel, if2.rf_we, if2.rf_wsel,
                      if2.br_sel, if2.pc_rst, if2.pc_write, if2.pc_sel,
                      if2.ir_load, if2.dm_we, if2.dm_re, if2.halted};

  function automatic logic [17:0] ex(input logic [3:0] s, input logic [1:0] alu);
    return {s, alu, 12'h000};
  endfunction

  task automatic check(input string nm, input logic [17:0] act, input logic [17:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic [3:0] m, input logic [3:0] s,
                     input logic a, input logic [17:0] e);
    tbl.push_back('{op: op, mm: m, st: s, ack: a, exp: e});
  endtask

  // Drive one cycle of inputs and queue the outputs expected in that cycle
  task automatic cyc(input logic sel, input logic [3:0] op, input logic [3:0] m,
                     input logic [3:0] s, input logic a, input logic [17:0] e,
                     input string nm);
    if (sel) begin
      if2.opcode = op; if2.mm = m; if2.stat = s; if2.mem_ack = a;
    end else begin
      if1.opcode = op; if1.mm = m; if1.stat = s; if1.mem_ack = a;
    end
    sb.push_back('{sel: sel, exp: e, name: nm});
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: compare queued expectations mid-cycle
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      cur_e = sb.pop_front();
      check(cur_e.name, cur_e.sel ? obs2 : obs1, cur_e.exp);
    end
  end

  initial begin
    fe  = ex(S_FETCH, P) | B_IRL | B_PCW;
    dec = ex(S_DECODE, P) | B_PCSEL;

    // ALU immediate from reset
    add(8, 8, 0, 1, ex(S_START1, P) | B_PCRST);
    add(8, 8, 0, 1, fe);
    add(8, 8, 0, 1, dec);
    add(8, 8, 0, 1, ex(S_EXECUTE, A));
    add(8, 8, 0, 1, ex(S_MEM, A));
    add(8, 8, 0, 1, ex(S_WB, P) | B_RFWE);
    // BRA taken, BNR not taken
    add(4, 2, 2, 1, fe);
    add(4, 2, 2, 1, dec | B_BR | B_PCW);
    add(7, 2, 2, 1, fe);
    add(7, 2, 2, 1, dec);
    // ALU register mode; ack low in MEM is ignored
    add(8, 3, 0, 1, fe);
    add(8, 3, 0, 1, dec);
    add(8, 3, 0, 1, ex(S_EXECUTE, Z));
    add(8, 3, 0, 0, ex(S_MEM, Z));
    add(8, 3, 0, 1, ex(S_WB, P) | B_RFWE);
    // LOD with one fetch wait and three data waits
    add(1, 0, 0, 0, ex(S_FETCH, P));
    add(1, 0, 0, 1, fe);
    add(1, 0, 0, 1, dec);
    add(1, 0, 0, 0, ex(S_EXECUTE, A));
    add(1, 0, 0, 0, ex(S_MEM, A) | B_DMRE);
    add(1, 0, 0, 0, ex(S_MEM, A) | B_DMRE);
    add(1, 0, 0, 0, ex(S_MEM, A) | B_DMRE);
    add(1, 0, 0, 1, ex(S_MEM, A) | B_DMRE);
    add(1, 0, 0, 0, ex(S_WB, P) | B_RFWE | W_MEM);
    // STR with two waits, straight back to FETCH
    add(2, 0, 0, 1, fe);
    add(2, 0, 0, 1, dec);
    add(2, 0, 0, 1, ex(S_EXECUTE, A));
    add(2, 0, 0, 0, ex(S_MEM, A) | B_DMWE);
    add(2, 0, 0, 0, ex(S_MEM, A) | B_DMWE);
    add(2, 0, 0, 1, ex(S_MEM, A) | B_DMWE);
    // SWP two write-backs
    add(3, 0, 0, 1, fe);
    add(3, 0, 0, 1, dec);
    add(3, 0, 0, 1, ex(S_EXECUTE, P));
    add(3, 0, 0, 0, ex(S_MEM, P));
    add(3, 0, 0, 1, ex(S_WB, P) | B_RFWE | W_RS);
    add(3, 0, 0, 1, ex(S_WB2, P) | B_RFWE | B_WSEL);
    // NOOP, undefined opcode, BNE taken, BRR not taken, HLT
    add(0, 0, 0, 1, fe);
    add(0, 0, 0, 1, dec);
    add(12, 0, 0, 1, fe);
    add(12, 0, 0, 1, dec);
    add(6, 2, 4, 1, fe);
    add(6, 2, 4, 1, dec | B_BR | B_PCW);
    add(5, 1, 2, 1, fe);
    add(5, 1, 2, 1, dec);
    add(15, 0, 0, 1, fe);
    add(15, 0, 0, 1, dec);

    if1.opcode = 4'd8; if1.mm = 4'd8; if1.stat = 4'd0; if1.mem_ack = 1'b1;
    if2.opcode = 4'd1; if2.mm = 4'd0; if2.stat = 4'd0; if2.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", obs1, ex(S_START1, P) | B_PCRST);
    rst_f = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      cyc(1'b0, tbl[i].op, tbl[i].mm, tbl[i].st, tbl[i].ack, tbl[i].exp,
          $sformatf("vec%0d", i));

    // HALT is sticky whatever mem_ack does
    for (int i = 0; i < 20; i++)
      cyc(1'b0, 4'd15, 4'($urandom), 4'($urandom), 1'($urandom),
          ex(S_HALT, P) | B_HALT, $sformatf("halt_hold%0d", i));

    // Asynchronous reset out of HALT
    #2 rst_f = 1'b0;
    #1 check("async_rst_halt", obs1, ex(S_START1, P) | B_PCRST);
    @(posedge clk);
    #1;
    rst_f = 1'b1;

    // STR interrupted by reset in its second wait cycle
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, ex(S_START1, P) | B_PCRST, "str_start1");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, fe, "str_fetch");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, dec, "str_decode");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b0, ex(S_EXECUTE, A), "str_exec");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b0, ex(S_MEM, A) | B_DMWE, "str_wait1");
    check("str_wait2", obs1, ex(S_MEM, A) | B_DMWE);
    #2 rst_f = 1'b0;
    #1 check("rst_midwait", obs1, ex(S_START1, P) | B_PCRST);
    @(posedge clk);
    #1;
    rst_f = 1'b1;
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, ex(S_START1, P) | B_PCRST, "rel_start1");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, fe, "rel_fetch");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, dec, "rel_decode");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, ex(S_EXECUTE, A), "rel_exec");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, ex(S_MEM, A) | B_DMWE, "rel_mem");
    cyc(1'b0, 4'd2, 4'd0, 4'd0, 1'b1, fe, "rel_no_wb");

    // Single-cycle memory build: LOD with mem_ack held low
    rst_f = 1'b0;
    @(posedge clk);
    #1;
    rst_f = 1'b1;
    cyc(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, ex(S_START1, P) | B_PCRST, "nack_start1");
    cyc(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, fe, "nack_fetch");
    cyc(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, dec, "nack_decode");
    cyc(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, ex(S_EXECUTE, A), "nack_exec");
    cyc(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, ex(S_MEM, A) | B_DMRE, "nack_mem");
    cyc(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, ex(S_WB, P) | B_RFWE | W_MEM, "nack_wb");
    cyc(1'b1, 4'd1, 4'd0, 4'd0, 1'b0, fe, "nack_refetch");

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
